// File: rtl/simproc_control.sv
// simproc_control: multicycle FSM sequencing the SimProc datapath; define SIMPROC_HALT_EN to make op 0001 (STOP) enter HALT
module simproc_control (
    input  logic       CLOCK_50,
    input  logic       RESETn,
    input  logic [7:0] OpCode,
    input  logic       N,
    input  logic       Z,
    output logic       PCwrite,
    output logic       AddrSel,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRload,
    output logic       MDRload,
    output logic       RASel,
    output logic       RFWrite,
    output logic       RegIn,
    output logic       ABLD,
    output logic       ALU_A,
    output logic       FlagWrite,
    output logic       ALUoutLD,
    output logic [2:0] ALU_B,
    output logic [2:0] ALUop,
    output logic       Halted,
    output logic [3:0] State
);
    typedef enum logic [3:0] {
        INIT   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        LOAD1  = 4'd3,
        LOAD2  = 4'd4,
        STORE  = 4'd5,
        ALU    = 4'd6,
        WB     = 4'd7,
        ORI    = 4'd8,
        ORIWB  = 4'd9,
        BR     = 4'd10,
        HALT   = 4'd11
    } state_t;
    state_t st, nxt;
    logic pc_r, ras_r, run, taken, unused_ok;
    assign unused_ok = ^OpCode[7:4];
    // next state: fixed sequencing, with the instruction decode taken in DECODE (ORI wins over the op nibble)
    always_comb begin
        nxt = FETCH;
        case (st)
            INIT:   nxt = run ? FETCH : INIT;
            FETCH:  nxt = DECODE;
            DECODE:
                if (OpCode[2:0] == 3'b111) nxt = ORI;
                else
                    case (OpCode[3:0])
                        4'b0000: nxt = LOAD1;
                        4'b0010: nxt = STORE;
                        4'b0100, 4'b0110, 4'b1000: nxt = ALU;
                        4'b0101, 4'b1001, 4'b1101: nxt = BR;
`ifdef SIMPROC_HALT_EN
                        4'b0001: nxt = HALT;
`endif
                        default: nxt = FETCH;
                    endcase
            LOAD1:  nxt = LOAD2;
            ALU:    nxt = WB;
            ORI:    nxt = ORIWB;
            HALT:   nxt = HALT;
            default: nxt = FETCH;
        endcase
    end
    // state plus outputs registered from the next state; run holds INIT for one extra edge after reset release
    always_ff @(posedge CLOCK_50 or negedge RESETn) begin
        if (!RESETn) begin
            st        <= INIT;
            run       <= 1'b0;
            pc_r      <= 1'b0;
            ras_r     <= 1'b0;
            AddrSel   <= 1'b0;
            MemRead   <= 1'b0;
            MemWrite  <= 1'b0;
            IRload    <= 1'b0;
            MDRload   <= 1'b0;
            RFWrite   <= 1'b0;
            RegIn     <= 1'b0;
            ABLD      <= 1'b0;
            ALU_A     <= 1'b0;
            FlagWrite <= 1'b0;
            ALUoutLD  <= 1'b0;
            ALU_B     <= 3'b000;
            ALUop     <= 3'b000;
`ifdef SIMPROC_HALT_EN
            Halted    <= 1'b0;
`endif
        end else begin
            st        <= nxt;
            run       <= 1'b1;
            pc_r      <= nxt == FETCH;
            ras_r     <= nxt == ORI || nxt == ORIWB;
            AddrSel   <= nxt == FETCH;
            MemRead   <= nxt == FETCH || nxt == LOAD1;
            MemWrite  <= nxt == STORE;
            IRload    <= nxt == FETCH;
            MDRload   <= nxt == LOAD1;
            RFWrite   <= nxt == LOAD2 || nxt == WB || nxt == ORIWB;
            RegIn     <= nxt == LOAD2;
            ABLD      <= nxt == DECODE;
            ALU_A     <= nxt == ALU || nxt == ORI;
            FlagWrite <= nxt == ALU || nxt == ORI;
            ALUoutLD  <= nxt == ALU || nxt == ORI;
            ALU_B     <= nxt == FETCH ? 3'b001 : nxt == ORI ? 3'b011 : nxt == BR ? 3'b010 : 3'b000;
            ALUop     <= nxt == ORI ? 3'b011 : nxt != ALU ? 3'b000 : OpCode[3] ? 3'b010 : OpCode[1] ? 3'b001 : 3'b000;
`ifdef SIMPROC_HALT_EN
            Halted    <= nxt == HALT;
`endif
        end
    end
`ifndef SIMPROC_HALT_EN
    assign Halted = 1'b0;
`endif
    assign taken   = OpCode[3:2] == 2'b01 ? Z : OpCode[3:2] == 2'b10 ? !Z : !N;
    assign PCwrite = pc_r | (st == BR && taken);
    assign RASel   = ras_r | (st == DECODE && OpCode[2:0] == 3'b111);
    assign State   = st;
endmodule

// File: tb/tb_simproc_control.sv
// tb_simproc_control: scoreboard bench for simproc_control, per-cycle state and output vector comparison
module tb_simproc_control;
    logic       CLOCK_50 = 1'b0;
    logic       RESETn = 1'b0;
    logic [7:0] OpCode = 8'h00;
    logic       N = 1'b0;
    logic       Z = 1'b0;
    logic       PCwrite, AddrSel, MemRead, MemWrite, IRload, MDRload;
    logic       RASel, RFWrite, RegIn, ABLD, ALU_A, FlagWrite, ALUoutLD, Halted;
    logic [2:0] ALU_B, ALUop;
    logic [3:0] State;
    logic [19:0] obs;
    typedef struct packed {
        logic [7:0] op;
        logic [3:0] st;
        logic [19:0] o;
    } rec_t;
    typedef struct packed {
        logic [7:0] op;
        logic       n;
        logic       z;
    } stim_t;
    rec_t sb[$];
    int errors = 0;
    int checks = 0;
    stim_t prog [15] = '{
        '{8'h14, 1'b0, 1'b0}, '{8'h5F, 1'b0, 1'b0}, '{8'hF5, 1'b0, 1'b1}, '{8'hF5, 1'b0, 1'b0},
        '{8'h20, 1'b0, 1'b0}, '{8'h26, 1'b1, 1'b0}, '{8'h38, 1'b0, 1'b1}, '{8'h12, 1'b0, 1'b0},
        '{8'hF9, 1'b0, 1'b0}, '{8'hF9, 1'b0, 1'b1}, '{8'hFD, 1'b0, 1'b0}, '{8'hFD, 1'b1, 1'b0},
        '{8'h03, 1'b0, 1'b0}, '{8'h07, 1'b0, 1'b0}, '{8'h0F, 1'b0, 1'b0}
    };

    always #10 CLOCK_50 = ~CLOCK_50;

    simproc_control dut (
        .CLOCK_50(CLOCK_50), .RESETn(RESETn), .OpCode(OpCode), .N(N), .Z(Z),
        .PCwrite(PCwrite), .AddrSel(AddrSel), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRload(IRload), .MDRload(MDRload), .RASel(RASel), .RFWrite(RFWrite), .RegIn(RegIn),
        .ABLD(ABLD), .ALU_A(ALU_A), .FlagWrite(FlagWrite), .ALUoutLD(ALUoutLD),
        .ALU_B(ALU_B), .ALUop(ALUop), .Halted(Halted), .State(State)
    );

    assign obs = {PCwrite, AddrSel, MemRead, MemWrite, IRload, MDRload, RASel, RFWrite, RegIn,
                  ABLD, ALU_A, FlagWrite, ALUoutLD, ALU_B, ALUop, Halted};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // expected outputs per state, straight from the control table
    function automatic logic [19:0] exp_o(input int s, input logic [7:0] op, input logic n, input logic z);
        logic pcw, adr, mr, mw, irl, mdr, ras, rfw, rin, abl, aa, fw, aol, hal;
        logic [2:0] ab, aop;
        {pcw, adr, mr, mw, irl, mdr, ras, rfw, rin, abl, aa, fw, aol, hal} = '0;
        ab = 3'b000;
        aop = 3'b000;
        case (s)
            1: begin pcw = 1; adr = 1; mr = 1; irl = 1; ab = 3'b001; end
            2: begin abl = 1; ras = op[2:0] == 3'b111; end
            3: begin mr = 1; mdr = 1; end
            4: begin rin = 1; rfw = 1; end
            5: mw = 1;
            6: begin
                aa = 1; aol = 1; fw = 1;
                aop = op[3:0] == 4'b0110 ? 3'b001 : op[3:0] == 4'b1000 ? 3'b010 : 3'b000;
            end
            7: rfw = 1;
            8: begin ras = 1; aa = 1; ab = 3'b011; aop = 3'b011; aol = 1; fw = 1; end
            9: begin ras = 1; rfw = 1; end
            10: begin
                ab = 3'b010;
                pcw = op[3:0] == 4'b0101 ? z : op[3:0] == 4'b1001 ? !z : !n;
            end
            11: hal = 1;
            default: ;
        endcase
        return {pcw, adr, mr, mw, irl, mdr, ras, rfw, rin, abl, aa, fw, aol, ab, aop, hal};
    endfunction

    // called at posedge+1 of the cycle before FETCH; keep>0 truncates the instruction to that many cycles
    task automatic issue(input logic [7:0] op, input logic n, input logic z, input int keep);
        int seq[$];
        int cnt;
        rec_t r;
        logic [3:0] lo;
        lo = op[3:0];
        seq.push_back(1);
        seq.push_back(2);
        if (op[2:0] == 3'b111) begin seq.push_back(8); seq.push_back(9); end
        else if (lo == 4'b0000) begin seq.push_back(3); seq.push_back(4); end
        else if (lo == 4'b0010) seq.push_back(5);
        else if (lo == 4'b0100 || lo == 4'b0110 || lo == 4'b1000) begin seq.push_back(6); seq.push_back(7); end
        else if (lo == 4'b0101 || lo == 4'b1001 || lo == 4'b1101) seq.push_back(10);
`ifdef SIMPROC_HALT_EN
        else if (lo == 4'b0001) repeat (100) seq.push_back(11);
`endif
        cnt = keep > 0 ? keep : seq.size();
        for (int i = 0; i < cnt; i++) begin
            r.op = op;
            r.st = seq[i][3:0];
            r.o = exp_o(seq[i], op, n, z);
            sb.push_back(r);
        end
        @(posedge CLOCK_50); #1;
        OpCode = op;
        N = n;
        Z = z;
        repeat (cnt - 1) begin @(posedge CLOCK_50); #1; end
    endtask

    task automatic do_reset();
        rec_t r;
        RESETn = 1'b0;
        #1;
        check("rst_state", {28'h0, State}, 32'h0);
        check("rst_outs", {12'h0, obs}, 32'h0);
        @(posedge CLOCK_50); #1;
        RESETn = 1'b1;
        r.op = OpCode;
        r.st = 4'd0;
        r.o = 20'h0;
        repeat (2) sb.push_back(r);
        @(posedge CLOCK_50); #1;
    endtask

    always @(negedge CLOCK_50) begin
        rec_t r;
        if (sb.size() > 0) begin
            r = sb.pop_front();
            check($sformatf("op%02h_st%0d", r.op, r.st), {8'h0, State, obs}, {8'h0, r.st, r.o});
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge CLOCK_50);
        #1;
        do_reset();
        foreach (prog[i]) issue(prog[i].op, prog[i].n, prog[i].z, 0);
        issue(8'h20, 1'b0, 1'b0, 3);
        @(posedge CLOCK_50); #1;
        check("load2_state", {28'h0, State}, 32'd4);
        do_reset();
        issue(8'h14, 1'b0, 1'b1, 0);
        issue(8'h01, 1'b0, 1'b0, 0);
        @(negedge CLOCK_50); #1;
        do_reset();
        issue(8'h26, 1'b0, 1'b0, 0);
        @(negedge CLOCK_50); #1;
        check("drain", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
